// File: rtl/fft_peak_detector.sv
// Tracks the largest-magnitude bin in the lower half of a serialized FFT frame and emits
// the peak index word, then the peak magnitude word. Optional: FFT_PEAK_DETECTOR_THRESHOLD_EN.
module fft_peak_detector #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg,
  output logic                 send_val,
  input  logic                 send_rdy
`ifdef FFT_PEAK_DETECTOR_THRESHOLD_EN
  ,
  input  logic [BIT_WIDTH-1:0] thresh_msg,
  input  logic                 thresh_val,
  output logic                 thresh_rdy
`endif
);

  localparam int CNT_W = $clog2(N_SAMPLES);
  localparam int IDX_W = $clog2(N_SAMPLES / 2);
  localparam logic [BIT_WIDTH-1:0] MIN_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [BIT_WIDTH-1:0] MAX_POS = ~MIN_NEG;

  if (DECIMAL_PT < 0 || DECIMAL_PT >= BIT_WIDTH) begin : g_bad_decimal_pt
    $error("DECIMAL_PT must lie inside the sample word");
  end

  typedef enum logic [1:0] {ACCUM, SEND_IDX, SEND_MAG} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [BIT_WIDTH-1:0] peak_mag_q, peak_mag_d;
  logic [IDX_W-1:0]     peak_idx_q, peak_idx_d;
  logic [BIT_WIDTH-1:0] mag;
  logic [BIT_WIDTH-1:0] idx_word;
  logic                 in_fire, out_fire;

  assign in_fire  = recv_val && recv_rdy;
  assign out_fire = send_val && send_rdy;

  // The most negative input has no positive twin, so it saturates.
  always_comb begin
    if (recv_msg == MIN_NEG)     mag = MAX_POS;
    else if (recv_msg[BIT_WIDTH-1]) mag = -recv_msg;
    else                         mag = recv_msg;
  end

`ifdef FFT_PEAK_DETECTOR_THRESHOLD_EN
  logic [BIT_WIDTH-1:0] thresh_q, thresh_d;

  assign thresh_rdy = (state_q == ACCUM) && (count_q == '0);

  always_comb begin
    thresh_d = thresh_q;
    if (thresh_val && thresh_rdy) thresh_d = thresh_msg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) thresh_q <= '0;
    else       thresh_q <= thresh_d;
  end

  assign idx_word = (peak_mag_q < thresh_q) ? '1 : BIT_WIDTH'(peak_idx_q);
`else
  assign idx_word = BIT_WIDTH'(peak_idx_q);
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ACCUM;
      count_q    <= '0;
      peak_mag_q <= '0;
      peak_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      peak_mag_q <= peak_mag_d;
      peak_idx_q <= peak_idx_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:    if (in_fire && (&count_q)) state_d = SEND_IDX;
      SEND_IDX: if (out_fire) state_d = SEND_MAG;
      SEND_MAG: if (out_fire) state_d = ACCUM;
      default:  state_d = ACCUM;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    peak_mag_d = peak_mag_q;
    peak_idx_d = peak_idx_q;
    if (in_fire) begin
      count_d = count_q + CNT_W'(1);
      // Upper half mirrors the lower half; strict compare keeps the lower index on ties.
      if (!count_q[CNT_W-1] && (mag > peak_mag_q)) begin
        peak_mag_d = mag;
        peak_idx_d = count_q[IDX_W-1:0];
      end
    end
    if ((state_q == SEND_MAG) && out_fire) begin
      peak_mag_d = '0;
      peak_idx_d = '0;
    end
  end

  always_comb begin
    recv_rdy = 1'b0;
    send_val = 1'b0;
    send_msg = '0;
    case (state_q)
      ACCUM:    recv_rdy = 1'b1;
      SEND_IDX: begin
        send_val = 1'b1;
        send_msg = idx_word;
      end
      SEND_MAG: begin
        send_val = 1'b1;
        send_msg = peak_mag_q;
      end
      default:  recv_rdy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed bench for fft_peak_detector with an 8-bin frame; inputs change and outputs are
// sampled on the falling clock edge.
module tb_fft_peak_detector;

  localparam int BW = 32;
  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] recv_msg;
  logic          recv_val;
  logic          recv_rdy;
  logic [BW-1:0] send_msg;
  logic          send_val;
  logic          send_rdy;
`ifdef FFT_PEAK_DETECTOR_THRESHOLD_EN
  logic [BW-1:0] thresh_msg;
  logic          thresh_val;
  logic          thresh_rdy;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fft_peak_detector #(.BIT_WIDTH(BW), .DECIMAL_PT(16), .N_SAMPLES(NS)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy)
`ifdef FFT_PEAK_DETECTOR_THRESHOLD_EN
    ,
    .thresh_msg (thresh_msg),
    .thresh_val (thresh_val),
    .thresh_rdy (thresh_rdy)
`endif
  );

  always #5 clk = ~clk;

  // Drives one frame; returns on the falling edge after the last sample's accept edge.
  task automatic drive_frame(input logic [BW-1:0] f [NS]);
    for (int i = 0; i < NS; i++) begin
      @(negedge clk);
      recv_val = 1'b1;
      recv_msg = f[i];
    end
    @(negedge clk);
    recv_val = 1'b0;
    recv_msg = '0;
  endtask

  // Called on a falling edge with send_rdy=1; captures one output word within a cycle budget.
  task automatic get_word(output logic [BW-1:0] w, output bit ok);
    ok = 1'b0;
    w  = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (send_val) begin
        w  = send_msg;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (ok) @(negedge clk);
  endtask

  task automatic run_frame(input logic [BW-1:0] f [NS], input logic [BW-1:0] exp_idx,
                           input logic [BW-1:0] exp_mag, input string name);
    logic [BW-1:0] w;
    bit ok;
    send_rdy = 1'b1;
    drive_frame(f);
    get_word(w, ok);
    n_cmp++;
    if (!ok || w !== exp_idx) begin
      n_err++;
      $display("FAIL %s index: got %h (valid seen %0d) expected %h", name, w, ok, exp_idx);
    end
    get_word(w, ok);
    n_cmp++;
    if (!ok || w !== exp_mag) begin
      n_err++;
      $display("FAIL %s magnitude: got %h (valid seen %0d) expected %h", name, w, ok, exp_mag);
    end
    n_cmp++;
    if (recv_rdy !== 1'b1 || send_val !== 1'b0) begin
      n_err++;
      $display("FAIL %s return to accum: recv_rdy=%b send_val=%b expected 1/0", name, recv_rdy, send_val);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (recv_rdy !== 1'b1 || send_val !== 1'b0 || send_msg !== '0) begin
      n_err++;
      $display("FAIL reset state: recv_rdy=%b send_val=%b send_msg=%h expected 1/0/0",
               recv_rdy, send_val, send_msg);
    end
  endtask

  task automatic test_basic();
    logic [BW-1:0] f [NS];
    f = '{32'd1, 32'hFFFF_FFFB, 32'd3, 32'd2, 32'd100, 32'd100, 32'd100, 32'd100};
    send_rdy = 1'b1;
    for (int i = 0; i < NS; i++) begin
      @(negedge clk);
      if (i == NS - 1) begin
        n_cmp++;
        if (send_val !== 1'b0) begin
          n_err++;
          $display("FAIL basic early valid: send_val=%b expected 0 before last accept", send_val);
        end
      end
      recv_val = 1'b1;
      recv_msg = f[i];
    end
    @(negedge clk);
    recv_val = 1'b0;
    n_cmp++;
    if (send_val !== 1'b1 || send_msg !== 32'd1 || recv_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL basic index latency: send_val=%b send_msg=%h recv_rdy=%b expected 1/00000001/0",
               send_val, send_msg, recv_rdy);
    end
    @(negedge clk);
    n_cmp++;
    if (send_val !== 1'b1 || send_msg !== 32'd5) begin
      n_err++;
      $display("FAIL basic magnitude: send_val=%b send_msg=%h expected 1/00000005", send_val, send_msg);
    end
    @(negedge clk);
    n_cmp++;
    if (send_val !== 1'b0 || recv_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL basic done: send_val=%b recv_rdy=%b expected 0/1", send_val, recv_rdy);
    end
  endtask

  task automatic test_tie();
    logic [BW-1:0] f [NS];
    f = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_frame(f, 32'd0, 32'd7, "tie");
  endtask

  task automatic test_saturation();
    logic [BW-1:0] f [NS];
    f = '{32'd0, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_frame(f, 32'd2, 32'h7FFF_FFFF, "saturation");
  endtask

  task automatic test_mirror_and_zero();
    logic [BW-1:0] f [NS];
    f = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FF00};
    run_frame(f, 32'd0, 32'd1, "mirror_half");
    f = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_frame(f, 32'd0, 32'd0, "all_zero");
  endtask

  task automatic test_back_pressure();
    logic [BW-1:0] f [NS];
    f = '{32'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    send_rdy = 1'b0;
    drive_frame(f);
    // Offer a stray sample during the stall; it must not be taken.
    recv_val = 1'b1;
    recv_msg = 32'd50;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (send_val !== 1'b1 || send_msg !== 32'd2 || recv_rdy !== 1'b0) begin
        n_err++;
        $display("FAIL stall cycle %0d: send_val=%b send_msg=%h recv_rdy=%b expected 1/00000002/0",
                 i, send_val, send_msg, recv_rdy);
      end
      @(negedge clk);
    end
    recv_val = 1'b0;
    recv_msg = '0;
    send_rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (send_val !== 1'b1 || send_msg !== 32'd4 || recv_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL stall release magnitude: send_val=%b send_msg=%h recv_rdy=%b expected 1/00000004/0",
               send_val, send_msg, recv_rdy);
    end
    @(negedge clk);
    n_cmp++;
    if (send_val !== 1'b0 || recv_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL stall release done: send_val=%b recv_rdy=%b expected 0/1", send_val, recv_rdy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [BW-1:0] f [NS];
    send_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      recv_val = 1'b1;
      recv_msg = 32'd50 + BW'(i);
    end
    @(negedge clk);
    recv_val = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (send_val !== 1'b0 || recv_rdy !== 1'b1) begin
        n_err++;
        $display("FAIL partial frame output cycle %0d: send_val=%b recv_rdy=%b expected 0/1",
                 i, send_val, recv_rdy);
      end
      @(negedge clk);
    end
    f = '{32'd0, 32'd0, 32'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0};
    run_frame(f, 32'd3, 32'd9, "after_reset");
  endtask

`ifdef FFT_PEAK_DETECTOR_THRESHOLD_EN
  task automatic load_thresh(input logic [BW-1:0] t);
    @(negedge clk);
    n_cmp++;
    if (thresh_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL thresh_rdy idle: got %b expected 1", thresh_rdy);
    end
    thresh_val = 1'b1;
    thresh_msg = t;
    @(negedge clk);
    thresh_val = 1'b0;
  endtask

  task automatic test_threshold();
    logic [BW-1:0] f [NS];
    f = '{32'd0, 32'd0, 32'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0};
    load_thresh(32'd10);
    run_frame(f, 32'hFFFF_FFFF, 32'd9, "below_threshold");
    load_thresh(32'd9);
    run_frame(f, 32'd3, 32'd9, "at_threshold");
  endtask
`endif

  initial begin
    reset    = 1'b0;
    recv_msg = '0;
    recv_val = 1'b0;
    send_rdy = 1'b1;
`ifdef FFT_PEAK_DETECTOR_THRESHOLD_EN
    thresh_msg = '0;
    thresh_val = 1'b0;
`endif
    test_reset();
    test_basic();
    test_tie();
    test_saturation();
    test_mirror_and_zero();
    test_back_pressure();
    test_reset_mid_frame();
`ifdef FFT_PEAK_DETECTOR_THRESHOLD_EN
    test_threshold();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
